// File: rtl/calc_pkg.sv
// Constants and helpers shared by the calculator display blocks:
// receiver FSM encoding, frame width and the 7-segment glyph table.
package calc_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rxState_t;

    // Glyphs for digits 0..9, bit order g..a; entry [0] is digit 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic isBcd(input logic [FRAME_BITS-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < FRAME_BITS / 4; i++)
            if (w[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high 7-segment decoder.
// Codes above 9 light nothing.
module bcd_to_7seg
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/display_rx.sv
// Serial BCD frame receiver with a 4-digit multiplexed 7-segment display.
// Frames are validated as a whole; only clean 16-bit BCD frames reach the display.
module display_rx
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 2000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_clk_in,
    input  logic        data_en_in,
    input  logic        data_in,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  digit_sel,
    output logic [6:0]  seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0] serClkSync, dataEnSync, dataSync;
    logic       ser_clk_s, data_en_s, data_s;
    logic       serClkPrev, dataEnPrev;
    logic       serRise, enRise, enFall;

    rxState_t                state, stateNext;
    logic [FRAME_BITS-1:0]   shiftReg;
    logic [4:0]              bitCnt;
    logic                    ovf;

    logic [CNT_W-1:0] refreshCnt;
    logic [1:0]       digitIdx;
    logic [3:0]       nibble;
    logic [15:0]      upper;
    logic             blank;
    logic [6:0]       segDec;

    assign ser_clk_s = serClkSync[1];
    assign data_en_s = dataEnSync[1];
    assign data_s    = dataSync[1];

    assign serRise = ser_clk_s & ~serClkPrev;
    assign enRise  = data_en_s & ~dataEnPrev;
    assign enFall  = ~data_en_s & dataEnPrev;

    always_ff @(posedge clk) begin
        if (rst) begin
            serClkSync <= '0;
            dataEnSync <= '0;
            dataSync   <= '0;
            serClkPrev <= 1'b0;
            dataEnPrev <= 1'b0;
        end else begin
            serClkSync <= {serClkSync[0], ser_clk_in};
            dataEnSync <= {dataEnSync[0], data_en_in};
            dataSync   <= {dataSync[0], data_in};
            serClkPrev <= ser_clk_s;
            dataEnPrev <= data_en_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (enRise) stateNext = SHIFT;
            SHIFT:   if (enFall) stateNext = CHECK;
            CHECK:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg    <= '0;
            bitCnt      <= '0;
            ovf         <= 1'b0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: if (enRise) begin
                    bitCnt <= '0;
                    ovf    <= 1'b0;
                end
                SHIFT: if (serRise && data_en_s) begin
                    // Extra edges only mark the frame bad; the first 16 bits stay put.
                    if (bitCnt < 5'(FRAME_BITS)) begin
                        shiftReg <= {shiftReg[FRAME_BITS-2:0], data_s};
                        bitCnt   <= bitCnt + 5'd1;
                    end else begin
                        ovf <= 1'b1;
                    end
                end
                CHECK: begin
                    if (bitCnt == 5'(FRAME_BITS) && !ovf && isBcd(shiftReg)) begin
                        value       <= shiftReg;
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign nibble = value[{digitIdx, 2'b00} +: 4];
    assign upper  = value >> {digitIdx, 2'b00};
    assign blank  = BLANK_LZ && (digitIdx != 2'd0) && (upper == 16'h0000);

    bcd_to_7seg uDecode (
        .bcd (nibble),
        .seg (segDec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            refreshCnt <= '0;
            digitIdx   <= 2'd0;
            digit_sel  <= 4'b0001;
            seg        <= 7'h3F;
        end else begin
            if (refreshCnt == CNT_W'(REFRESH_DIV - 1)) begin
                refreshCnt <= '0;
                digitIdx   <= digitIdx + 2'd1;
            end else begin
                refreshCnt <= refreshCnt + 1'b1;
            end
            digit_sel <= 4'b0001 << digitIdx;
            seg       <= blank ? 7'h00 : segDec;
        end
    end

endmodule
